p3_execute: RTL

P3_EXECUTE -- requirements
Module: p3_execute

---
 rtl/p3_execute.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/p3_execute.sv
// Execute stage: ALU, flag register, branch resolution and squash/halt sequencing.
// All outputs are registered on clockp3, one cycle after the decode inputs.
module p3_execute #(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic        clockp3,
    input  logic        reset_n,
    input  logic [15:0] alu1,
    input  logic [15:0] alu2,
    input  logic [3:0]  opcode,
    input  logic        writereg,
    input  logic [1:0]  memwrite,
    input  logic [2:0]  regaddress,
    input  logic [15:0] address,
    input  logic [15:0] storedata,
    input  logic        isbranch,
    input  logic [2:0]  cond,
    input  logic [15:0] pcp2,
    input  logic [15:0] indata,
    output logic [15:0] result,
    output logic        writeregout,
    output logic [1:0]  memwriteout,
    output logic [2:0]  regaddressout,
    output logic [15:0] addressout,
    output logic [15:0] storedataout,
    output logic        branchtaken,
    output logic [15:0] branchtarget,
    output logic [3:0]  flags,
    output logic [15:0] outdata,
    output logic        outvalid,
    output logic        halted
);
    localparam int CW = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);

    typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    flags_q;
    logic [15:0]   result_q, addressout_q, storedataout_q, branchtarget_q, outdata_q;
    logic          writeregout_q, branchtaken_q, outvalid_q, halted_q;
    logic [1:0]    memwriteout_q;
    logic [2:0]    regaddressout_q;

    logic          alu_cls, squashed, taken, cond_ok;
    logic          upd_flags, wr_en, is_out, is_hlt;
    logic [15:0]   alu_res, res_d, rol_w;
    logic          c_d, v_d;
    logic [16:0]   add_w, sub_w, sll_w, srl_w, sra_w;
    logic [3:0]    shamt;
    logic [3:0]    flags_d;

    assign alu_cls  = (memwrite == 2'b00) && !isbranch;
    assign squashed = (state_q != RUN);
    assign shamt    = alu1[3:0];

    // Carry/borrow come out of bit 16; shifts use a 17th bit to catch the last bit out.
    assign add_w = {1'b0, alu2} + {1'b0, alu1};
    assign sub_w = {1'b0, alu2} - {1'b0, alu1};
    assign sll_w = {1'b0, alu2} << shamt;
    assign srl_w = {alu2, 1'b0} >> shamt;
    assign sra_w = 17'($signed({alu2, 1'b0}) >>> shamt);
    assign rol_w = (alu2 << shamt) | (alu2 >> (5'd16 - {1'b0, shamt}));

    always_comb begin
        alu_res   = 16'h0000;
        c_d       = 1'b0;
        v_d       = 1'b0;
        upd_flags = 1'b0;
        wr_en     = writereg;
        is_out    = 1'b0;
        is_hlt    = 1'b0;
        case (opcode)
            4'd0: begin
                alu_res = add_w[15:0]; c_d = add_w[16]; upd_flags = 1'b1;
                v_d = (alu2[15] == alu1[15]) && (add_w[15] != alu2[15]);
            end
            4'd1, 4'd5: begin
                alu_res = sub_w[15:0]; c_d = sub_w[16]; upd_flags = 1'b1;
                v_d = (alu2[15] != alu1[15]) && (sub_w[15] != alu2[15]);
                if (opcode == 4'd5) wr_en = 1'b0;
            end
            4'd2:  begin alu_res = alu2 & alu1; upd_flags = 1'b1; end
            4'd3:  begin alu_res = alu2 | alu1; upd_flags = 1'b1; end
            4'd4:  begin alu_res = alu2 ^ alu1; upd_flags = 1'b1; end
            4'd6:  alu_res = alu1;
            4'd8:  begin alu_res = sll_w[15:0]; c_d = sll_w[16]; upd_flags = 1'b1; end
            4'd9:  begin
                alu_res = rol_w; c_d = (shamt != 4'd0) && rol_w[0]; upd_flags = 1'b1;
            end
            4'd10: begin alu_res = srl_w[16:1]; c_d = srl_w[0]; upd_flags = 1'b1; end
            4'd11: begin alu_res = sra_w[16:1]; c_d = sra_w[0]; upd_flags = 1'b1; end
            4'd12: alu_res = indata;
            4'd13: begin is_out = 1'b1; wr_en = 1'b0; end
            4'd15: begin is_hlt = 1'b1; wr_en = 1'b0; end
            default: wr_en = 1'b0;
        endcase
        if (!alu_cls) begin
            upd_flags = 1'b0;
            wr_en     = writereg;
            is_out    = 1'b0;
            is_hlt    = 1'b0;
        end
    end

    assign res_d   = alu_cls ? alu_res : address;
    assign flags_d = {alu_res[15], alu_res == 16'h0000, c_d, v_d};

    // Conditions see the flags as they stood before this edge (flags_q = {S,Z,C,V}).
    always_comb begin
        cond_ok = 1'b0;
        if (cond == 3'd4) cond_ok = 1'b1;
        else if (cond == 3'd7) begin
            case (regaddress)
                3'd0:    cond_ok = flags_q[2];
                3'd1:    cond_ok = flags_q[3] ^ flags_q[0];
                3'd2:    cond_ok = flags_q[2] | (flags_q[3] ^ flags_q[0]);
                3'd3:    cond_ok = !flags_q[2];
                default: cond_ok = 1'b0;
            endcase
        end
    end

    assign taken = !squashed && isbranch && cond_ok;

    always_ff @(posedge clockp3 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            flags_q         <= 4'h0;
            result_q        <= 16'h0000;
            writeregout_q   <= 1'b0;
            memwriteout_q   <= 2'b00;
            regaddressout_q <= 3'd0;
            addressout_q    <= 16'h0000;
            storedataout_q  <= 16'h0000;
            branchtaken_q   <= 1'b0;
            branchtarget_q  <= 16'h0000;
            outdata_q       <= 16'h0000;
            outvalid_q      <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            result_q        <= res_d;
            regaddressout_q <= regaddress;
            addressout_q    <= address;
            storedataout_q  <= storedata;
            writeregout_q   <= !squashed && wr_en;
            memwriteout_q   <= squashed ? 2'b00 : memwrite;
            outvalid_q      <= !squashed && is_out;
            branchtaken_q   <= taken;
            if (taken) branchtarget_q <= pcp2 + 16'd1 + address;
            if (!squashed && is_out) outdata_q <= alu2;
            if (!squashed && upd_flags) flags_q <= flags_d;
            case (state_q)
                RUN: begin
                    if (is_hlt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (taken && SQUASH_DEPTH > 0) begin
                        state_q <= SQUASH;
                        cnt_q   <= CW'(SQUASH_DEPTH);
                    end
                end
                SQUASH: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) state_q <= RUN;
                end
                default: halted_q <= 1'b1;
            endcase
        end
    end

    assign result        = result_q;
    assign writeregout   = writeregout_q;
    assign memwriteout   = memwriteout_q;
    assign regaddressout = regaddressout_q;
    assign addressout    = addressout_q;
    assign storedataout  = storedataout_q;
    assign branchtaken   = branchtaken_q;
    assign branchtarget  = branchtarget_q;
    assign flags         = flags_q;
    assign outdata       = outdata_q;
    assign outvalid      = outvalid_q;
    assign halted        = halted_q;
endmodule
